// File: rtl/instr_fetch.sv
// Instruction-fetch stage: 64-word Harvard instruction memory read at the PC,
// delivered to decode through a valid/ready IR with a one-entry skid buffer.
module instr_fetch #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               pc_stall,
    input  logic               flush,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic               ir_valid,
    output logic [INSTR_W-1:0] ir_data,
    output logic [ADDR_W-1:0]  ir_pc,
    input  logic               ir_ready
);

    typedef enum logic {S_RUN, S_PROG} state_t;

    state_t state_q, state_d;

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] rd_data;

    logic               ir_valid_q, ir_valid_d;
    logic [INSTR_W-1:0] ir_data_q, ir_data_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               sk_v_q, sk_v_d;
    logic [INSTR_W-1:0] sk_data_q, sk_data_d;
    logic [ADDR_W-1:0]  sk_pc_q, sk_pc_d;

    logic issue;
    logic consume;

    // Program memory is deliberately outside the reset domain so a loaded
    // program survives reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign rd_data = mem_q[pc_addr];

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (prog_we)  state_d = S_PROG;
            S_PROG:  if (!prog_we) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // FSM: outputs. The stall depends only on registered state and prog_we,
    // never on ir_ready, so the PC sees no combinational path from decode.
    always_comb begin
        pc_stall = sk_v_q | prog_we | (state_q == S_PROG);
        issue    = (state_q == S_RUN) & ~pc_stall & ~flush;
    end

    assign consume = ir_valid_q & ir_ready;

    always_comb begin
        ir_valid_d = ir_valid_q;
        ir_data_d  = ir_data_q;
        ir_pc_d    = ir_pc_q;
        sk_v_d     = sk_v_q;
        sk_data_d  = sk_data_q;
        sk_pc_d    = sk_pc_q;
        if (flush || prog_we) begin
            ir_valid_d = 1'b0;
            sk_v_d     = 1'b0;
        end else if (issue) begin
            // issue implies an empty skid, so only IR occupancy matters here
            if (!ir_valid_q || ir_ready) begin
                ir_valid_d = 1'b1;
                ir_data_d  = rd_data;
                ir_pc_d    = pc_addr;
            end else begin
                sk_v_d    = 1'b1;
                sk_data_d = rd_data;
                sk_pc_d   = pc_addr;
            end
        end else if (consume) begin
            if (sk_v_q) begin
                ir_data_d = sk_data_q;
                ir_pc_d   = sk_pc_q;
                sk_v_d    = 1'b0;
            end else begin
                ir_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_valid_q <= 1'b0;
            ir_data_q  <= '0;
            ir_pc_q    <= '0;
            sk_v_q     <= 1'b0;
            sk_data_q  <= '0;
            sk_pc_q    <= '0;
        end else begin
            ir_valid_q <= ir_valid_d;
            ir_data_q  <= ir_data_d;
            ir_pc_q    <= ir_pc_d;
            sk_v_q     <= sk_v_d;
            sk_data_q  <= sk_data_d;
            sk_pc_q    <= sk_pc_d;
        end
    end

    assign ir_valid = ir_valid_q;
    assign ir_data  = ir_data_q;
    assign ir_pc    = ir_pc_q;

endmodule
